pkmc_sdram_arbiter: RTL and testbench
=====================================

# pkmc_sdram_arbiter

Three-port Wishbone arbiter that shares the single SDRAM controller master port of the PKMC memory controller between the display fetch unit (DVGA), the CPU and the JPEG DMA. It grants one requester at a time for the full duration of its Wishbone cycle. It also defers new grants while the SDRAM controller requests an auto-refresh window, and acknowledges that request (sdramIRQ/sdramIRQack handshake) only when the bus is idle. A per-grant timeout terminates a stuck transfer with an error.

## Interface
- AW, 32, address width per port
- DW, 32, data width per port
- TIMEOUT, 255, max cycles in GRANT with stb high and no m_ack before error (≥2)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- s_cyc  in  3  per-port Wishbone cycle; bit 0 = DVGA, bit 1 = CPU, bit 2 = JPEG DMA
- s_stb  in  3  per-port strobe
- s_we  in  3  per-port write enable
- s_adr  in  3*AW  per-port address, port k at [k*AW +: AW]
- s_dat_i  in  3*DW  per-port write data
- s_sel  in  3*DW/8  per-port byte selects
- s_dat_o  out  DW  read data, common to all ports (valid only with own ack)
- s_ack  out  3  per-port acknowledge
- s_err  out  3  per-port error (timeout)
- m_cyc, m_stb, m_we  out  1  to SDRAM controller
- m_adr  out  AW;  m_dat_o  out  DW;  m_sel  out  DW/8  to SDRAM controller
- m_dat_i  in  DW  read data from controller
- m_ack  in  1  acknowledge from controller
- ref_req  in  1  refresh request (controller sdramIRQ)
- ref_ack  out  1  refresh grant (controller sdramIRQack)
- gnt  out  2  current owner index, valid while m_cyc high (debug/status)

## Operation
- States: IDLE, GRANT, RELEASE, REFRESH. Reset: IDLE, gnt=0, rr_last=2, timeout counter 0, all outputs 0.
- IDLE: if ref_req=1 -> REFRESH (refresh beats pending requests). Else if any s_cyc set -> register winner into gnt, -> GRANT. Else stay.
- Winner: port 0 has fixed highest priority. Otherwise ports 1/2 round-robin: the port not equal to rr_last wins if requesting, else the other. rr_last updates to the winner when the winner is 1 or 2; unchanged when port 0 wins.
- GRANT: m_cyc=1; m_stb, m_we, m_adr, m_dat_o, m_sel = selected port's signals (combinational mux on registered gnt). s_ack[gnt]=m_ack & s_stb[gnt]; s_dat_o=m_dat_i; other ack/err bits 0. Exit when s_cyc[gnt]=0 -> RELEASE. ref_req is ignored in GRANT.
- Timeout: counter clears on m_ack or when s_stb[gnt]=0; increments while s_stb[gnt]=1 and m_ack=0. When counter reaches TIMEOUT: s_err[gnt]=1 for exactly one cycle, m_stb forced 0 that cycle, -> RELEASE. The counter saturates and never wraps. Width is clog2(TIMEOUT+1).
- RELEASE: m_cyc=0 for one cycle (the controller sees a cycle boundary, so no back-to-back ownership across masters) -> IDLE.
- REFRESH: m_cyc=0, ref_ack=1 held while ref_req=1. When ref_req drops -> IDLE, ref_ack=0 in the following cycle.
- Reset assertion in any state forces IDLE and zeroes all outputs immediately, without waiting for a clock edge. A transfer cut off by reset is not completed.

## Timing
- Request latency: s_cyc rises in cycle N while IDLE -> m_cyc=1 in N+1.
- Ack is combinational from m_ack, giving zero added latency on the data path. Address/control are combinational from the ports, with one mux delay.
- End of transfer: s_cyc[gnt] low in cycle N -> RELEASE in N+1 -> IDLE in N+2 -> the earliest next m_cyc is N+3.
- ref_req high in IDLE in cycle N -> ref_ack=1 in N+1.
- Simultaneous ref_req and s_cyc in IDLE: REFRESH wins; the request is served after ref_req falls (IDLE, then GRANT the next cycle).
- Timeout: m_stb held with no m_ack for TIMEOUT cycles -> s_err pulse in the next cycle.

## Test plan
- Single CPU read: s_cyc[1]/s_stb[1], adr 0x100, m_ack after 4 cycles -> m_cyc at N+1, gnt=1, s_ack[1] one cycle coincident with m_ack, s_dat_o=m_dat_i, RELEASE gap of 1 cycle.
- Contention: ports 1 and 2 request continuously, 3 transfers each -> grants alternate 1,2,1,2,1,2. Port 0 raised mid-sequence -> port 0 takes the next grant, then the alternation resumes where it left off.
- Refresh: ref_req asserted during a port-2 burst -> ref_ack stays 0 until RELEASE; ref_ack=1 one cycle after IDLE; pending port-1 request granted only after ref_req falls.
- Timeout with TIMEOUT=8: stb held, m_ack never -> s_err[gnt]=1 exactly once after 8 cycles, then m_cyc=0 and the next requester is granted.
- Reset mid-GRANT: rst low -> m_cyc, s_ack, ref_ack, gnt at 0 asynchronously. After release of rst, state is IDLE and port 1 wins the first 1-vs-2 tie.

Source files
------------

// File: rtl/pkmc_sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pkmc_sdram_arbiter : 3-port Wishbone arbiter (DVGA/CPU/JPEG) for the SDRAM
// controller master port, with refresh deferral and per-grant timeout. Rev 1.0
// ============================================================================
module pkmc_sdram_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        s_cyc,
  input  logic [2:0]        s_stb,
  input  logic [2:0]        s_we,
  input  logic [3*AW-1:0]   s_adr,
  input  logic [3*DW-1:0]   s_dat_i,
  input  logic [3*DW/8-1:0] s_sel,
  output logic [DW-1:0]     s_dat_o,
  output logic [2:0]        s_ack,
  output logic [2:0]        s_err,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [AW-1:0]     m_adr,
  output logic [DW-1:0]     m_dat_o,
  output logic [DW/8-1:0]   m_sel,
  input  logic [DW-1:0]     m_dat_i,
  input  logic              m_ack,
  input  logic              ref_req,
  output logic              ref_ack,
  output logic [1:0]        gnt
);

  localparam int              c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_GRANT   = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;
  localparam logic [1:0] c_REFRESH = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [1:0]         r_gnt;
  logic [1:0]         r_rrLast;
  logic [c_CNT_W-1:0] r_toCnt;
  logic [1:0]         w_winner;
  logic               w_selCyc;
  logic               w_selStb;
  logic               w_selWe;
  logic [AW-1:0]      w_selAdr;
  logic [DW-1:0]      w_selDat;
  logic [DW/8-1:0]    w_selSel;
  logic               w_timeout;
  logic               w_startGrant;

  // Port 0 has fixed priority; ports 1/2 alternate, favouring the one not served last
  always_comb begin
    w_winner = 2'd2;
    if (s_cyc[0]) begin
      w_winner = 2'd0;
    end else if (s_cyc[1] && s_cyc[2]) begin
      w_winner = (r_rrLast == 2'd1) ? 2'd2 : 2'd1;
    end else if (s_cyc[1]) begin
      w_winner = 2'd1;
    end
  end

  always_comb begin
    w_selCyc = 1'b0;
    w_selStb = 1'b0;
    w_selWe  = 1'b0;
    w_selAdr = '0;
    w_selDat = '0;
    w_selSel = '0;
    for (int k = 0; k < 3; k++) begin
      if (r_gnt == 2'(k)) begin
        w_selCyc = s_cyc[k];
        w_selStb = s_stb[k];
        w_selWe  = s_we[k];
        w_selAdr = s_adr[k*AW +: AW];
        w_selDat = s_dat_i[k*DW +: DW];
        w_selSel = s_sel[k*(DW/8) +: DW/8];
      end
    end
  end

  assign w_timeout    = (r_state == c_GRANT) && (r_toCnt == c_TIMEOUT);
  assign w_startGrant = (r_state == c_IDLE) && !ref_req && (|s_cyc);
  assign gnt          = r_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_IDLE;
      r_gnt    <= 2'd0;
      r_rrLast <= 2'd2;
      r_toCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_startGrant) begin
        r_gnt <= w_winner;
        if (w_winner != 2'd0) begin
          r_rrLast <= w_winner;
        end
      end
      // Saturating stall counter: only stalled strobe cycles of the owner count
      if ((r_state != c_GRANT) || m_ack || !w_selStb) begin
        r_toCnt <= '0;
      end else if (r_toCnt != c_TIMEOUT) begin
        r_toCnt <= r_toCnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (ref_req) begin
          w_nextState = c_REFRESH;
        end else if (|s_cyc) begin
          w_nextState = c_GRANT;
        end
      end
      c_GRANT: begin
        if (!w_selCyc || w_timeout) begin
          w_nextState = c_RELEASE;
        end
      end
      c_RELEASE: w_nextState = c_IDLE;
      c_REFRESH: begin
        if (!ref_req) begin
          w_nextState = c_IDLE;
        end
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_o = '0;
    m_sel   = '0;
    s_dat_o = '0;
    s_ack   = 3'b000;
    s_err   = 3'b000;
    ref_ack = 1'b0;
    case (r_state)
      c_GRANT: begin
        m_cyc   = 1'b1;
        m_stb   = w_selStb && !w_timeout;
        m_we    = w_selWe;
        m_adr   = w_selAdr;
        m_dat_o = w_selDat;
        m_sel   = w_selSel;
        s_dat_o = m_dat_i;
        for (int k = 0; k < 3; k++) begin
          if (r_gnt == 2'(k)) begin
            s_ack[k] = m_ack && w_selStb && !w_timeout;
            s_err[k] = w_timeout;
          end
        end
      end
      c_REFRESH: ref_ack = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pkmc_sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pkmc_sdram_arbiter : directed self-checking bench for pkmc_sdram_arbiter.
// Rev 1.0
// ============================================================================
module tb_pkmc_sdram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk;
  logic              rst;
  logic [2:0]        s_cyc;
  logic [2:0]        s_stb;
  logic [2:0]        s_we;
  logic [3*AW-1:0]   s_adr;
  logic [3*DW-1:0]   s_dat_i;
  logic [3*DW/8-1:0] s_sel;
  logic [DW-1:0]     s_dat_o;
  logic [2:0]        s_ack;
  logic [2:0]        s_err;
  logic              m_cyc;
  logic              m_stb;
  logic              m_we;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_dat_o;
  logic [DW/8-1:0]   m_sel;
  logic [DW-1:0]     m_dat_i;
  logic              m_ack;
  logic              ref_req;
  logic              ref_ack;
  logic [1:0]        gnt;

  logic [31:0] adrTab [3];
  int nChecks;
  int nPass;

  pkmc_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_i(s_dat_i), .s_sel(s_sel), .s_dat_o(s_dat_o),
    .s_ack(s_ack), .s_err(s_err),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_o(m_dat_o), .m_sel(m_sel), .m_dat_i(m_dat_i), .m_ack(m_ack),
    .ref_req(ref_req), .ref_ack(ref_ack), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ref_req = 1'b1;
    m_dat_i = 32'h1234_5678;
    #2;
    nChecks++; if (m_cyc !== 1'b0) $display("FAIL reset_m_cyc got %0b exp 0", m_cyc); else nPass++;
    nChecks++; if (gnt !== 2'd0) $display("FAIL reset_gnt got %0d exp 0", gnt); else nPass++;
    nChecks++; if (s_ack !== 3'b000 || s_err !== 3'b000) $display("FAIL reset_ack_err got ack %b err %b exp 000 000", s_ack, s_err); else nPass++;
    nChecks++; if (s_dat_o !== 32'h0) $display("FAIL reset_s_dat_o got %h exp 0", s_dat_o); else nPass++;
    tick;
    nChecks++; if (ref_ack !== 1'b0) $display("FAIL reset_ref_ack got %0b exp 0", ref_ack); else nPass++;
    ref_req = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    nChecks++; if (m_cyc !== 1'b0 || ref_ack !== 1'b0) $display("FAIL idle_after_reset got m_cyc %0b ref_ack %0b exp 0 0", m_cyc, ref_ack); else nPass++;
  endtask

  task automatic test_contention;
    int expSeq [7];
    int rem [4];
    expSeq = '{1, 2, 1, 0, 2, 1, 2};
    rem    = '{1, 3, 3, 0};
    s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
    s_cyc[2] = 1'b1; s_stb[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int k;
      logic [1:0] g;
      k = 0;
      while (m_cyc !== 1'b1 && k < 10) begin
        tick;
        k++;
      end
      nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'(expSeq[i])) $display("FAIL contention_gnt[%0d] got m_cyc %0b gnt %0d exp 1 %0d", i, m_cyc, gnt, expSeq[i]); else nPass++;
      nChecks++; if (m_adr !== adrTab[expSeq[i]]) $display("FAIL contention_adr[%0d] got %h exp %h", i, m_adr, adrTab[expSeq[i]]); else nPass++;
      g = gnt;
      if (i == 2) begin
        s_cyc[0] = 1'b1; s_stb[0] = 1'b1;
      end
      m_ack = 1'b1;
      #1;
      nChecks++; if (s_ack !== 3'(1 << expSeq[i])) $display("FAIL contention_ack[%0d] got %b exp %b", i, s_ack, 3'(1 << expSeq[i])); else nPass++;
      tick;
      m_ack = 1'b0;
      s_cyc[g] = 1'b0; s_stb[g] = 1'b0;
      rem[g] = rem[g] - 1;
      tick;
      nChecks++; if (m_cyc !== 1'b0) $display("FAIL contention_release[%0d] got m_cyc %0b exp 0", i, m_cyc); else nPass++;
      if (rem[g] > 0) begin
        s_cyc[g] = 1'b1; s_stb[g] = 1'b1;
      end
    end
    tick;
    tick;
    nChecks++; if (m_cyc !== 1'b0) $display("FAIL contention_idle_end got m_cyc %0b exp 0", m_cyc); else nPass++;
  endtask

  task automatic test_single_read;
    s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
    m_dat_i = 32'hDEAD_BEEF;
    #1;
    nChecks++; if (m_cyc !== 1'b0) $display("FAIL read_latency_n got m_cyc %0b exp 0", m_cyc); else nPass++;
    tick;
    nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'd1 || m_stb !== 1'b1) $display("FAIL read_grant got m_cyc %0b gnt %0d m_stb %0b exp 1 1 1", m_cyc, gnt, m_stb); else nPass++;
    nChecks++; if (m_adr !== 32'h100 || m_we !== 1'b0 || m_sel !== 4'h3) $display("FAIL read_ctrl got adr %h we %0b sel %h exp 100 0 3", m_adr, m_we, m_sel); else nPass++;
    nChecks++; if (m_dat_o !== 32'hC1C1_C1C1) $display("FAIL read_dat_o got %h exp c1c1c1c1", m_dat_o); else nPass++;
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (s_ack !== 3'b000) $display("FAIL read_no_ack[%0d] got %b exp 000", i, s_ack); else nPass++;
      tick;
    end
    m_ack = 1'b1;
    #1;
    nChecks++; if (s_ack !== 3'b010) $display("FAIL read_ack got %b exp 010", s_ack); else nPass++;
    nChecks++; if (s_dat_o !== 32'hDEAD_BEEF) $display("FAIL read_data got %h exp deadbeef", s_dat_o); else nPass++;
    tick;
    m_ack = 1'b0;
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0;
    #1;
    nChecks++; if (s_ack !== 3'b000 || m_cyc !== 1'b1) $display("FAIL read_ack_one_cycle got ack %b m_cyc %0b exp 000 1", s_ack, m_cyc); else nPass++;
    tick;
    nChecks++; if (m_cyc !== 1'b0) $display("FAIL read_release got m_cyc %0b exp 0", m_cyc); else nPass++;
    tick;
  endtask

  task automatic test_refresh;
    s_cyc[2] = 1'b1; s_stb[2] = 1'b1;
    tick;
    nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'd2) $display("FAIL refresh_grant2 got m_cyc %0b gnt %0d exp 1 2", m_cyc, gnt); else nPass++;
    nChecks++; if (m_we !== 1'b1 || m_sel !== 4'hF || m_dat_o !== 32'hC2C2_C2C2 || m_adr !== 32'h2000) $display("FAIL refresh_port2_mux got we %0b sel %h dat %h adr %h exp 1 f c2c2c2c2 2000", m_we, m_sel, m_dat_o, m_adr); else nPass++;
    ref_req = 1'b1;
    s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
    #1;
    nChecks++; if (ref_ack !== 1'b0) $display("FAIL refresh_in_grant got ref_ack %0b exp 0", ref_ack); else nPass++;
    tick;
    nChecks++; if (ref_ack !== 1'b0 || m_cyc !== 1'b1) $display("FAIL refresh_grant_held got ref_ack %0b m_cyc %0b exp 0 1", ref_ack, m_cyc); else nPass++;
    m_ack = 1'b1;
    tick;
    m_ack = 1'b0;
    s_cyc[2] = 1'b0; s_stb[2] = 1'b0;
    tick;
    nChecks++; if (ref_ack !== 1'b0 || m_cyc !== 1'b0) $display("FAIL refresh_release got ref_ack %0b m_cyc %0b exp 0 0", ref_ack, m_cyc); else nPass++;
    tick;
    nChecks++; if (ref_ack !== 1'b0 || m_cyc !== 1'b0) $display("FAIL refresh_idle got ref_ack %0b m_cyc %0b exp 0 0", ref_ack, m_cyc); else nPass++;
    tick;
    nChecks++; if (ref_ack !== 1'b1 || m_cyc !== 1'b0) $display("FAIL refresh_ack got ref_ack %0b m_cyc %0b exp 1 0", ref_ack, m_cyc); else nPass++;
    tick;
    nChecks++; if (ref_ack !== 1'b1 || m_cyc !== 1'b0) $display("FAIL refresh_hold got ref_ack %0b m_cyc %0b exp 1 0", ref_ack, m_cyc); else nPass++;
    ref_req = 1'b0;
    tick;
    nChecks++; if (ref_ack !== 1'b0 || m_cyc !== 1'b0) $display("FAIL refresh_drop got ref_ack %0b m_cyc %0b exp 0 0", ref_ack, m_cyc); else nPass++;
    tick;
    nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'd1) $display("FAIL refresh_pending_grant got m_cyc %0b gnt %0d exp 1 1", m_cyc, gnt); else nPass++;
    m_ack = 1'b1;
    tick;
    m_ack = 1'b0;
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    s_cyc[0] = 1'b1; s_stb[0] = 1'b1;
    s_cyc[2] = 1'b1; s_stb[2] = 1'b1;
    tick;
    nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'd0) $display("FAIL timeout_grant0 got m_cyc %0b gnt %0d exp 1 0", m_cyc, gnt); else nPass++;
    for (int i = 0; i < TO; i++) begin
      nChecks++; if (s_err !== 3'b000 || m_stb !== 1'b1) $display("FAIL timeout_wait[%0d] got err %b m_stb %0b exp 000 1", i, s_err, m_stb); else nPass++;
      tick;
    end
    nChecks++; if (s_err !== 3'b001 || m_stb !== 1'b0 || m_cyc !== 1'b1) $display("FAIL timeout_err got err %b m_stb %0b m_cyc %0b exp 001 0 1", s_err, m_stb, m_cyc); else nPass++;
    s_cyc[0] = 1'b0; s_stb[0] = 1'b0;
    tick;
    nChecks++; if (s_err !== 3'b000 || m_cyc !== 1'b0) $display("FAIL timeout_release got err %b m_cyc %0b exp 000 0", s_err, m_cyc); else nPass++;
    tick;
    tick;
    nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'd2) $display("FAIL timeout_next_grant got m_cyc %0b gnt %0d exp 1 2", m_cyc, gnt); else nPass++;
    m_ack = 1'b1;
    tick;
    m_ack = 1'b0;
    s_cyc[2] = 1'b0; s_stb[2] = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid_grant;
    s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
    tick;
    m_ack = 1'b1;
    ref_req = 1'b1;
    #1;
    nChecks++; if (s_ack !== 3'b010 || gnt !== 2'd1) $display("FAIL rstmid_pre got ack %b gnt %0d exp 010 1", s_ack, gnt); else nPass++;
    #2;
    rst = 1'b0;
    #1;
    nChecks++; if (m_cyc !== 1'b0 || s_ack !== 3'b000) $display("FAIL rstmid_async got m_cyc %0b ack %b exp 0 000", m_cyc, s_ack); else nPass++;
    nChecks++; if (gnt !== 2'd0 || ref_ack !== 1'b0 || m_stb !== 1'b0 || m_adr !== 32'h0) $display("FAIL rstmid_outputs got gnt %0d ref_ack %0b m_stb %0b adr %h exp 0 0 0 0", gnt, ref_ack, m_stb, m_adr); else nPass++;
    tick;
    nChecks++; if (ref_ack !== 1'b0 || m_cyc !== 1'b0) $display("FAIL rstmid_held got ref_ack %0b m_cyc %0b exp 0 0", ref_ack, m_cyc); else nPass++;
    m_ack = 1'b0;
    ref_req = 1'b0;
    rst = 1'b1;
    s_cyc = 3'b110; s_stb = 3'b110;
    tick;
    nChecks++; if (m_cyc !== 1'b1 || gnt !== 2'd1) $display("FAIL rstmid_tie got m_cyc %0b gnt %0d exp 1 1", m_cyc, gnt); else nPass++;
    s_cyc = 3'b000; s_stb = 3'b000;
    tick;
    tick;
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    adrTab  = '{32'h1000, 32'h100, 32'h2000};
    rst     = 1'b0;
    s_cyc   = 3'b000;
    s_stb   = 3'b000;
    s_we    = 3'b100;
    s_adr   = {adrTab[2], adrTab[1], adrTab[0]};
    s_dat_i = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    s_sel   = {4'hF, 4'h3, 4'h1};
    m_dat_i = 32'h0;
    m_ack   = 1'b0;
    ref_req = 1'b0;
    test_reset;
    test_contention;
    test_single_read;
    test_refresh;
    test_timeout;
    test_reset_mid_grant;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
